// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (16,11) SECDED correction stage.
// Block bit k is stream position k: 0 = overall parity, 1/2/4/8 = check
// bits, all other positions carry data.
package hamming_pkg;

  localparam int unsigned BLK_W  = 16;
  localparam int unsigned DATA_W = 11;
  localparam int unsigned SYN_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT
  } state_t;

  // Block positions of the data bits, in serial output order.
  localparam logic [SYN_W-1:0] DATA_POS [0:DATA_W-1] = '{
    4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
  };

endpackage

// File: rtl/hamming_fix.sv
// Combinational SECDED check and single-bit correction of one 16-bit block.
// Ports:
//   i_blk    - received block, bit k = stream position k
//   o_syn    - XOR of the indices of all set bits
//   o_par    - XOR of all 16 bits
//   o_fixed  - block with bit o_syn flipped when a single error is seen
//   o_single - single error (correctable, includes position 0)
//   o_double - double error (syndrome set, overall parity even)
module hamming_fix
  import hamming_pkg::*;
(
  input  logic [BLK_W-1:0] i_blk,
  output logic [SYN_W-1:0] o_syn,
  output logic             o_par,
  output logic [BLK_W-1:0] o_fixed,
  output logic             o_single,
  output logic             o_double
);

  always_comb begin
    o_syn = '0;
    for (int unsigned k = 1; k < BLK_W; k++) begin
      if (i_blk[k]) begin
        o_syn = o_syn ^ SYN_W'(k);
      end
    end
    o_par    = ^i_blk;
    o_single = o_par;
    o_double = !o_par && (o_syn != '0);
    // Odd parity means one flipped bit; syn==0 then points at the parity bit.
    o_fixed  = i_blk;
    if (o_par) begin
      o_fixed[o_syn] = ~i_blk[o_syn];
    end
  end

endmodule

// File: rtl/hamming_corrector.sv
// Hamming (16,11) SECDED corrector: accepts one block, checks/corrects it in
// one cycle, then shifts the 11 data bits out with a valid/ready handshake.
// Parameters:
//   DROP_ON_DED - 1: discard double-error blocks; 0: shift them out with out_err
//   CNT_W       - width of the optional error counters
// Optional feature macro: HAMMING_CORRECTOR_ERRCNT_EN adds saturating
// cnt_sec / cnt_ded counters (cleared only by reset).
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_blk/in_valid/in_ready       - block input handshake
//   out_bit/out_valid/out_ready    - serial data output handshake
//   out_last              - 11th data bit of the block
//   out_err               - block is uncorrectable (held for the whole block)
//   err_single/err_double/err_pos  - status of the last checked block
//   stat_valid            - one-cycle pulse when the status updates
module hamming_corrector
  import hamming_pkg::*;
#(
  parameter int unsigned DROP_ON_DED = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BLK_W-1:0] in_blk,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_err,
  output logic             err_single,
  output logic             err_double,
  output logic [SYN_W-1:0] err_pos,
  output logic             stat_valid
`ifdef HAMMING_CORRECTOR_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] cnt_sec,
  output logic [CNT_W-1:0] cnt_ded
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(DATA_W - 1);

  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_t           r_state;
  state_t           w_next;
  logic [BLK_W-1:0] r_blk;
  logic [3:0]       r_cnt;
  logic             r_err;
  logic             r_single;
  logic             r_double;
  logic [SYN_W-1:0] r_pos;

  logic [SYN_W-1:0] w_syn;
  logic             w_par;
  logic [BLK_W-1:0] w_fixed;
  logic             w_single;
  logic             w_double;
  logic [SYN_W-1:0] w_pos;

  hamming_fix u_fix (
    .i_blk    (r_blk),
    .o_syn    (w_syn),
    .o_par    (w_par),
    .o_fixed  (w_fixed),
    .o_single (w_single),
    .o_double (w_double)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (in_valid) w_next = CHECK;
      CHECK: w_next = (w_double && (DROP_ON_DED != 0)) ? IDLE : SHIFT;
      SHIFT: if (out_ready && (r_cnt == LAST_IDX)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture, correction write-back, bit counter, status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blk    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_pos    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_err <= 1'b0;
          if (in_valid) begin
            r_blk <= in_blk;
          end
        end
        CHECK: begin
          r_blk    <= w_fixed;
          r_cnt    <= '0;
          r_err    <= w_double;
          r_single <= w_single;
          r_double <= w_double;
          r_pos    <= w_single ? w_syn : '0;
        end
        SHIFT: begin
          if (out_ready && (r_cnt != LAST_IDX)) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Block position of the data bit currently presented
  always_comb begin
    w_pos = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (r_cnt == 4'(i)) begin
        w_pos = DATA_POS[i];
      end
    end
  end

  // Outputs. During CHECK the status is driven straight from the checker so
  // that stat_valid and the new err_* values appear in the same cycle; the
  // registered copy holds them afterwards.
  always_comb begin
    in_ready   = (r_state == IDLE);
    out_valid  = (r_state == SHIFT);
    out_bit    = (r_state == SHIFT) ? r_blk[w_pos] : 1'b0;
    out_last   = (r_state == SHIFT) && (r_cnt == LAST_IDX);
    out_err    = (r_state == SHIFT) && r_err;
    stat_valid = (r_state == CHECK);
    if (r_state == CHECK) begin
      err_single = w_single;
      err_double = w_double;
      err_pos    = w_single ? w_syn : '0;
    end else begin
      err_single = r_single;
      err_double = r_double;
      err_pos    = r_pos;
    end
  end

`ifdef HAMMING_CORRECTOR_ERRCNT_EN
  logic [CNT_W-1:0] r_cnt_sec;
  logic [CNT_W-1:0] r_cnt_ded;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt_sec <= '0;
      r_cnt_ded <= '0;
    end else if (r_state == CHECK) begin
      if (w_single && (r_cnt_sec != '1)) begin
        r_cnt_sec <= r_cnt_sec + 1'b1;
      end
      if (w_double && (r_cnt_ded != '1)) begin
        r_cnt_ded <= r_cnt_ded + 1'b1;
      end
    end
  end

  assign cnt_sec = r_cnt_sec;
  assign cnt_ded = r_cnt_ded;
`endif

endmodule

// File: tb/tb_hamming_corrector.sv
// Self-checking bench for hamming_corrector: scoreboard queues of expected
// serial bits and status, filled when a block is driven and drained when the
// DUT produces output. A second instance covers DROP_ON_DED=1.
module tb_hamming_corrector;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_blk;
  logic        in_valid;
  logic        in_ready;
  logic        out_bit;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_err;
  logic        err_single;
  logic        err_double;
  logic [3:0]  err_pos;
  logic        stat_valid;

  logic [15:0] d_in_blk;
  logic        d_in_valid;
  logic        d_in_ready;
  logic        d_out_bit;
  logic        d_out_valid;
  logic        d_out_last;
  logic        d_out_err;
  logic        d_err_single;
  logic        d_err_double;
  logic [3:0]  d_err_pos;
  logic        d_stat_valid;

`ifdef HAMMING_CORRECTOR_ERRCNT_EN
  logic [7:0] cnt_sec;
  logic [7:0] cnt_ded;
  logic [7:0] d_cnt_sec;
  logic [7:0] d_cnt_ded;
`endif

  hamming_corrector #(.DROP_ON_DED(0), .CNT_W(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_blk     (in_blk),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_err    (out_err),
    .err_single (err_single),
    .err_double (err_double),
    .err_pos    (err_pos),
    .stat_valid (stat_valid)
`ifdef HAMMING_CORRECTOR_ERRCNT_EN
    ,
    .cnt_sec    (cnt_sec),
    .cnt_ded    (cnt_ded)
`endif
  );

  hamming_corrector #(.DROP_ON_DED(1), .CNT_W(8)) u_drop (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_blk     (d_in_blk),
    .in_valid   (d_in_valid),
    .in_ready   (d_in_ready),
    .out_bit    (d_out_bit),
    .out_valid  (d_out_valid),
    .out_ready  (1'b1),
    .out_last   (d_out_last),
    .out_err    (d_out_err),
    .err_single (d_err_single),
    .err_double (d_err_double),
    .err_pos    (d_err_pos),
    .stat_valid (d_stat_valid)
`ifdef HAMMING_CORRECTOR_ERRCNT_EN
    ,
    .cnt_sec    (d_cnt_sec),
    .cnt_ded    (d_cnt_ded)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic b; logic last; logic err;} obit_t;
  typedef struct packed {logic s; logic d; logic [3:0] pos;} stat_t;

  obit_t q_bits[$];
  stat_t q_stat[$];
  int unsigned idx;
  int unsigned n_checks;
  int unsigned n_errors;

  // Serial data, first output bit in the MSB
  localparam logic [10:0] CLEAN_BITS = 11'b00110010110;
  localparam logic [10:0] DED_BITS   = 11'b00010010010;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [10:0] bits, input logic s, input logic d,
                          input logic [3:0] pos, input logic err);
    for (int i = 10; i >= 0; i--) begin
      q_bits.push_back('{b: bits[i], last: (i == 0), err: err});
    end
    q_stat.push_back('{s: s, d: d, pos: pos});
  endtask

  // Drive one block into u_dut; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] blk);
    int unsigned t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_timeout", {15'd0, in_ready}, 16'd1);
    in_blk   = blk;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned t;
    t = 0;
    while (!(in_ready && q_bits.size() == 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", {15'd0, in_ready}, 16'd1);
  endtask

  task automatic wait_idx(input int unsigned n);
    int unsigned t;
    t = 0;
    while (idx != n && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idx_timeout", 16'(idx), 16'(n));
  endtask

  // Scoreboard consumer: handshake observed at negedge completes at next posedge
  always @(negedge clk) begin
    obit_t e;
    stat_t s;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q_bits.size() == 0) begin
          chk("unexpected_bit", 16'd1, 16'd0);
        end else begin
          e = q_bits.pop_front();
          chk("out_bit", {15'd0, out_bit}, {15'd0, e.b});
          chk("out_last", {15'd0, out_last}, {15'd0, e.last});
          chk("out_err", {15'd0, out_err}, {15'd0, e.err});
          idx = e.last ? 0 : idx + 1;
        end
      end
      if (stat_valid) begin
        if (q_stat.size() == 0) begin
          chk("unexpected_stat", 16'd1, 16'd0);
        end else begin
          s = q_stat.pop_front();
          chk("err_single", {15'd0, err_single}, {15'd0, s.s});
          chk("err_double", {15'd0, err_double}, {15'd0, s.d});
          chk("err_pos", {12'd0, err_pos}, {12'd0, s.pos});
        end
      end
    end
  end

  initial begin
    logic held;
    n_checks   = 0;
    n_errors   = 0;
    idx        = 0;
    rst_n      = 1'b0;
    in_blk     = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    d_in_blk   = '0;
    d_in_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_stat_valid", {15'd0, stat_valid}, 16'd0);
    chk("rst_err", {13'd0, err_single, err_double, out_err}, 16'd0);
    chk("rst_err_pos", {12'd0, err_pos}, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Clean block with latency check
    push_exp(CLEAN_BITS, 1'b0, 1'b0, 4'd0, 1'b0);
    send(16'h69C3);
    @(negedge clk);
    chk("lat_stat_n1", {15'd0, stat_valid}, 16'd1);
    chk("lat_outv_n1", {15'd0, out_valid}, 16'd0);
    chk("lat_inrdy_n1", {15'd0, in_ready}, 16'd0);
    @(negedge clk);
    chk("lat_outv_n2", {15'd0, out_valid}, 16'd1);
    @(posedge clk); #1;
    wait_idle();

    // Single error at bit 11
    push_exp(CLEAN_BITS, 1'b1, 1'b0, 4'd11, 1'b0);
    send(16'h61C3);
    wait_idle();

    // Overall parity bit error
    push_exp(CLEAN_BITS, 1'b1, 1'b0, 4'd0, 1'b0);
    send(16'h69C2);
    wait_idle();

    // Double error, shifted out uncorrected
    push_exp(DED_BITS, 1'b0, 1'b1, 4'd0, 1'b1);
    send(16'h4983);
    wait_idle();
    chk("ded_hold_double", {15'd0, err_double}, 16'd1);
    chk("ded_out_err_clr", {15'd0, out_err}, 16'd0);

    // Double error on the dropping instance
    d_in_blk   = 16'h4983;
    d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    chk("drop_stat", {15'd0, d_stat_valid}, 16'd1);
    chk("drop_double", {15'd0, d_err_double}, 16'd1);
    chk("drop_outv_n1", {15'd0, d_out_valid}, 16'd0);
    @(negedge clk);
    chk("drop_inrdy_n2", {15'd0, d_in_ready}, 16'd1);
    chk("drop_outv_n2", {15'd0, d_out_valid}, 16'd0);
    @(posedge clk); #1;
    // Single errors are still shifted out by the dropping instance
    d_in_blk   = 16'h61C3;
    d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_sec_outv", {15'd0, d_out_valid}, 16'd1);
    chk("drop_sec_bit0", {15'd0, d_out_bit}, 16'd0);
    repeat (12) @(posedge clk);
    #1;

    // Backpressure at bit 5 with in_valid held high during SHIFT
    push_exp(CLEAN_BITS, 1'b0, 1'b0, 4'd0, 1'b0);
    send(16'h69C3);
    push_exp(CLEAN_BITS, 1'b1, 1'b0, 4'd11, 1'b0);
    in_blk   = 16'h61C3;
    in_valid = 1'b1;
    wait_idx(5);
    out_ready = 1'b0;
    held      = out_bit;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_out_bit", {15'd0, out_bit}, {15'd0, held});
      chk("bp_out_valid", {15'd0, out_valid}, 16'd1);
      chk("bp_in_ready", {15'd0, in_ready}, 16'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idx(0);
    chk("ovl_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of the shift
    push_exp(CLEAN_BITS, 1'b0, 1'b0, 4'd0, 1'b0);
    send(16'h69C3);
    wait_idx(7);
    rst_n     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    q_bits.delete();
    idx = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    push_exp(CLEAN_BITS, 1'b0, 1'b0, 4'd0, 1'b0);
    send(16'h69C3);
    wait_idle();

`ifdef HAMMING_CORRECTOR_ERRCNT_EN
    chk("cnt_sec_after_rst", {8'd0, cnt_sec}, 16'd0);
    for (int i = 0; i < 300; i++) begin
      push_exp(CLEAN_BITS, 1'b1, 1'b0, 4'd11, 1'b0);
      send(16'h61C3);
    end
    wait_idle();
    chk("cnt_sec_sat", {8'd0, cnt_sec}, 16'd255);
    chk("cnt_ded_zero", {8'd0, cnt_ded}, 16'd0);
    push_exp(DED_BITS, 1'b0, 1'b1, 4'd0, 1'b1);
    send(16'h4983);
    wait_idle();
    chk("cnt_ded_one", {8'd0, cnt_ded}, 16'd1);
    chk("cnt_sec_hold", {8'd0, cnt_sec}, 16'd255);
`endif

    chk("sb_bits_empty", 16'(q_bits.size()), 16'd0);
    chk("sb_stat_empty", 16'(q_stat.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hamming_corrector.md
Name: hamming_corrector

Overview:
- Downstream stage of the serial Hamming (16,11) SECDED decoder path.
- Accepts one received 16-bit block and recomputes the 4-bit syndrome and the overall parity.
- Corrects a single-bit error, flags a double-bit error, extracts the 11 data bits and shifts them out serially one bit per handshake.
- Block bit k is stream position k: position 0 is overall parity; 1, 2, 4, 8 are check bits; 3, 5, 6, 7, 9..15 are data.

Parameters:
- DROP_ON_DED, 0: 1 = discard a double-error block (no serial output); 0 = shift it out uncorrected with out_err=1.
- CNT_W, 8: width of the error counters (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_blk  in  16  received block; bit k = stream position k.
- in_valid  in  1  in_blk valid.
- in_ready  out  1  block accepted when in_valid and in_ready are both high.
- out_bit  out  1  current data bit.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_last  out  1  marks the 11th data bit of a block.
- out_err  out  1  block was uncorrectable; constant for the whole block.
- err_single  out  1  last block had a single error, now corrected.
- err_double  out  1  last block had a double error.
- err_pos  out  4  corrected position; 0 if none.
- stat_valid  out  1  one-cycle pulse when the err_* outputs update.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0 except in_ready=1. Any partial block is discarded, including a reset mid-shift.
- States: IDLE, CHECK, SHIFT.
  - IDLE: in_ready=1. On in_valid, capture in_blk and go to CHECK.
  - CHECK (1 cycle): in_ready=0.
    - syn = XOR of indices of set bits; par = XOR of all 16 bits.
    - syn=0, par=0: clean.
    - syn≠0, par=1: single error; flip bit syn; err_pos=syn.
    - syn=0, par=1: single error at position 0; flip bit 0; err_pos=0; data unaffected.
    - syn≠0, par=0: double error; no flip; err_pos=0.
    - Register err_single, err_double, err_pos; pulse stat_valid.
    - Next state: SHIFT, or IDLE if double error and DROP_ON_DED=1.
  - SHIFT: present data bits in positions 3, 5, 6, 7, 9, 10, ..., 15 order.
    - out_valid=1.
    - Advance one bit per cycle with out_valid and out_ready both high.
    - out_bit and out_last hold stable while out_ready=0.
    - out_last=1 on the 11th bit. When that bit is accepted, go to IDLE.
- Latency: accept at edge N; stat_valid high in cycle N+1; first out_valid in cycle N+2. Best case is 11 output cycles per block and 13 cycles accept-to-accept.
- err_single, err_double and err_pos hold until the next CHECK. out_err holds for SHIFT and clears on return to IDLE.
- No overlap: in_ready=0 in CHECK and SHIFT; in_valid is ignored there.
- The bit counter is 4 bits wide, counts 0..10, and never wraps past 10.

Optional Feature:
- Macro: HAMMING_CORRECTOR_ERRCNT_EN.
- Defined: add ports cnt_sec (out, CNT_W) and cnt_ded (out, CNT_W).
  - Each increments once per block in CHECK for single or double errors respectively.
  - Both saturate at all-ones and clear only on reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hamming_pkg holds:
  - BLK_W=16, DATA_W=11, SYN_W=4.
  - State enum {IDLE, CHECK, SHIFT}.
  - Constant array DATA_POS[0:10] = {3,5,6,7,9..15}.
- One sub-module: hamming_fix, combinational. Input: block. Outputs: syn, par, corrected block, single/double flags. The top holds the FSM, bit counter and registers.

Test Plan:
- Clean block: in_blk=16'h69C3 -> err_single=0, err_double=0; serial output 0,0,1,1,0,0,1,0,1,1,0; out_last on the 11th bit; first out_valid 2 cycles after accept.
- Single error at bit 11: in_blk=16'h61C3 -> err_single=1, err_pos=11, out_err=0; same 11 bits as the clean case.
- Parity-bit error: in_blk=16'h69C2 -> err_single=1, err_pos=0; same data out.
- Double error at bits 6 and 13: in_blk=16'h4983 -> err_double=1, err_pos=0.
  - DROP_ON_DED=0: uncorrected bits 0,0,0,1,0,0,1,0,0,1,0 with out_err=1.
  - DROP_ON_DED=1: no out_valid; in_ready=1 two cycles after accept.
- Backpressure and overlap: out_ready=0 for 3 cycles at bit 5 -> out_bit stable, no bit lost. in_valid held high during SHIFT -> not accepted until IDLE.
- Reset and counters: rst_n=0 at bit 7 -> next cycle out_valid=0, in_ready=1; the next block outputs cleanly. With the macro, 300 single-error blocks at CNT_W=8 -> cnt_sec=255.
